// File: rtl/vp_frame_writer.sv
// Pulls one pixel per single-cycle ready tick from the vp FIFO and writes it to the frame buffer at a per-frame wrapping raster address.
// Tick to write request is 2 cycles, best case 1 pixel / 4 cycles; a stalled write (i_mem_ready=0) holds everything and blocks new ticks.
module vp_frame_writer #(
  parameter int DW = 12,
  parameter int RL = 640,
  parameter int NL = 480,
  parameter int AW = 19
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_enable,
  input  logic          i_addr_clr,
  output logic          o_data_ready,
  input  logic          i_data_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_mem_wr,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_data,
  input  logic          i_mem_ready,
  output logic          o_frame_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(RL * NL - 1);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t        state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic          clr_pend, clr_pend_n;
  logic          clr_now;
  logic          ready_n, wr_n, done_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_data_n;

  // A clear seen while a pixel is in flight waits for that pixel's accept.
  assign clr_now = clr_pend | i_addr_clr;

  always_comb begin
    state_n    = state;
    addr_n     = addr;
    clr_pend_n = clr_pend;
    ready_n    = 1'b0;
    wr_n       = o_mem_wr;
    mem_addr_n = o_mem_addr;
    mem_data_n = o_mem_data;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        clr_pend_n = 1'b0;
        if (i_addr_clr) addr_n = '0;
        if (i_enable && i_data_valid) begin
          ready_n = 1'b1;
          state_n = RD;
        end
      end
      RD: begin
        clr_pend_n = clr_now;
        state_n    = CAP;
      end
      CAP: begin
        clr_pend_n = clr_now;
        mem_data_n = i_data;
        mem_addr_n = addr;
        wr_n       = 1'b1;
        state_n    = WR;
      end
      WR: begin
        clr_pend_n = clr_now;
        if (i_mem_ready) begin
          wr_n       = 1'b0;
          clr_pend_n = 1'b0;
          state_n    = IDLE;
          if (clr_now) begin
            addr_n = '0;
          end else if (addr == LAST_ADDR) begin
            addr_n = '0;
            done_n = 1'b1;
          end else begin
            addr_n = addr + AW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state        <= IDLE;
      addr         <= '0;
      clr_pend     <= 1'b0;
      o_data_ready <= 1'b0;
      o_mem_wr     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_n;
      addr         <= addr_n;
      clr_pend     <= clr_pend_n;
      o_data_ready <= ready_n;
      o_mem_wr     <= wr_n;
      o_mem_addr   <= mem_addr_n;
      o_mem_data   <= mem_data_n;
      o_frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_vp_frame_writer.sv
// Bench for vp_frame_writer: a queue-backed FIFO, a transaction-level address/data model, directed and random scenarios.
module tb_vp_frame_writer;
  localparam int DW = 12;
  localparam int RL = 4;
  localparam int NL = 2;
  localparam int AW = 4;
  localparam int FRAME = RL * NL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, enable, addr_clr, data_valid, mem_ready;
  logic [DW-1:0] data;
  logic          data_ready, mem_wr, frame_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  vp_frame_writer #(.DW(DW), .RL(RL), .NL(NL), .AW(AW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_enable(enable), .i_addr_clr(addr_clr),
    .o_data_ready(data_ready), .i_data_valid(data_valid), .i_data(data),
    .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
    .i_mem_ready(mem_ready), .o_frame_done(frame_done)
  );

  int vectors = 0;
  int miscompares = 0;

  // FIFO contents, pixels popped but not yet written, and the expected address state.
  logic [DW-1:0] pix_q[$];
  logic [DW-1:0] popped_q[$];
  bit            valid_en;
  int            m_addr;
  bit            m_pend, m_busy;
  int            cyc, tick_cyc;
  bit            acc, exp_done, exp_tick;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data, acc_exp_data;
  int            acc_exp_addr;

  function automatic void upd_valid();
    data_valid = valid_en && (pix_q.size() >= 2);
  endfunction

  task automatic load(input int n);
    for (int i = 0; i < n; i++) pix_q.push_back(DW'($urandom));
    upd_valid();
  endtask

  // One clock: sample pre-edge values, wait for the edge, then update FIFO and model at the negedge.
  task automatic step();
    logic p_wr, p_mr, p_tick, p_clr, p_rst, p_en, p_val;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    bit was_busy;
    p_wr = mem_wr; p_mr = mem_ready; p_tick = data_ready; p_clr = addr_clr;
    p_rst = rstn; p_en = enable; p_val = data_valid; p_addr = mem_addr; p_data = mem_data;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (p_tick === 1'b1 && pix_q.size() > 0) begin
      data = pix_q.pop_front();
      popped_q.push_back(data);
    end else begin
      data = DW'($urandom);
    end
    acc = 1'b0; exp_done = 1'b0; exp_tick = 1'b0;
    if (p_rst !== 1'b1) begin
      m_addr = 0; m_pend = 1'b0; m_busy = 1'b0;
      popped_q.delete();
    end else begin
      was_busy = m_busy;
      if (p_clr === 1'b1) begin
        if (m_busy) m_pend = 1'b1;
        else m_addr = 0;
      end
      if (p_wr === 1'b1 && p_mr === 1'b1) begin
        acc = 1'b1; acc_addr = p_addr; acc_data = p_data; acc_exp_addr = m_addr;
        if (popped_q.size() > 0) acc_exp_data = popped_q.pop_front();
        else acc_exp_data = 'x;
        exp_done = !m_pend && (m_addr == FRAME - 1);
        m_addr = (m_pend || m_addr == FRAME - 1) ? 0 : m_addr + 1;
        m_pend = 1'b0; m_busy = 1'b0;
      end
      if (!was_busy && p_en === 1'b1 && p_val === 1'b1) begin
        exp_tick = 1'b1; m_busy = 1'b1;
      end
    end
    if (data_ready === 1'b1) tick_cyc = cyc;
    upd_valid();
  endtask

  // kind 0: ready tick, 1: write request high, 2: write accepted. n = steps taken, -1 on timeout.
  task automatic wait_ev(input int kind, output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if ((kind == 0 && data_ready === 1'b1) || (kind == 1 && mem_wr === 1'b1) || (kind == 2 && acc)) begin
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic drain();
    enable = 1'b0; mem_ready = 1'b1; addr_clr = 1'b0;
    repeat (8) step();
    pix_q.delete(); upd_valid();
  endtask

  task automatic do_reset();
    rstn = 1'b0; step(); rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; valid_en = 1'b1; mem_ready = 1'b1; addr_clr = 1'b0;
    load(4);
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({data_ready, mem_wr, frame_done} !== 3'b000 || mem_addr !== '0 || mem_data !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: ready=%b wr=%b done=%b addr=%h data=%h, required all zero",
                 i, data_ready, mem_wr, frame_done, mem_addr, mem_data);
      end
    end
    enable = 1'b0; rstn = 1'b1;
    step();
    vectors++;
    if (data_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_tick: ready=%b, required 0", data_ready);
    end
    pix_q.delete(); upd_valid();
  endtask

  task automatic test_single_pixel();
    int n;
    pix_q.push_back(12'hABC); pix_q.push_back(12'h123); pix_q.push_back(12'h456);
    valid_en = 1'b1; mem_ready = 1'b1; enable = 1'b1; upd_valid();
    wait_ev(0, n);
    vectors++;
    if (n < 0) begin miscompares++; $display("FAIL single_tick: no ready tick, required one"); end
    step();
    vectors++;
    if (data_ready !== 1'b0) begin miscompares++; $display("FAIL single_tick_width: ready=%b, required 0", data_ready); end
    step();
    vectors++;
    if (mem_wr !== 1'b1 || mem_addr !== 4'd0 || mem_data !== 12'hABC) begin
      miscompares++;
      $display("FAIL single_write: wr=%b addr=%h data=%h, required wr=1 addr=0 data=abc", mem_wr, mem_addr, mem_data);
    end
    step();
    vectors++;
    if (!acc || mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL single_write_width: accepted=%0d wr=%b, required accepted=1 wr=0", acc, mem_wr);
    end
    wait_ev(2, n);
    vectors++;
    if (n < 0 || acc_addr !== 4'd1 || acc_data !== 12'h123) begin
      miscompares++;
      $display("FAIL single_next_write: steps=%0d addr=%h data=%h, required addr=1 data=123", n, acc_addr, acc_data);
    end
    drain();
  endtask

  task automatic test_stall();
    int n;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    load(3); enable = 1'b1; mem_ready = 1'b0;
    wait_ev(1, n);
    a = mem_addr; d = mem_data;
    vectors++;
    if (n < 0 || a !== AW'(m_addr) || popped_q.size() == 0 || d !== popped_q[0]) begin
      miscompares++;
      $display("FAIL stall_first_write: steps=%0d addr=%h data=%h, required addr=%h and the popped pixel", n, a, d, AW'(m_addr));
    end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (mem_wr !== 1'b1 || mem_addr !== a || mem_data !== d || data_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold cycle %0d: wr=%b addr=%h data=%h ready=%b, required wr=1 addr=%h data=%h ready=0",
                 i, mem_wr, mem_addr, mem_data, data_ready, a, d);
      end
    end
    mem_ready = 1'b1;
    step();
    vectors++;
    if (!acc || mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_accept: accepted=%0d wr=%b, required accepted=1 wr=0", acc, mem_wr);
    end
    wait_ev(0, n);
    vectors++;
    if (n != 1) begin miscompares++; $display("FAIL stall_next_tick: tick after %0d cycles, required 1", n); end
    drain();
  endtask

  task automatic test_frame_wrap();
    int k, dones;
    do_reset();
    load(11); enable = 1'b1; mem_ready = 1'b1;
    k = 0; dones = 0;
    for (int i = 0; i < 100 && k < 10; i++) begin
      step();
      if (frame_done === 1'b1) begin
        dones++;
        vectors++;
        if (!(acc && acc_addr === AW'(FRAME - 1))) begin
          miscompares++;
          $display("FAIL wrap_done_place: done with accepted=%0d addr=%h, required accept at addr %0d", acc, acc_addr, FRAME - 1);
        end
      end
      if (acc) begin
        vectors++;
        if (acc_addr !== AW'(k % FRAME) || acc_data !== acc_exp_data) begin
          miscompares++;
          $display("FAIL wrap_write %0d: addr=%h data=%h, required addr=%h data=%h", k, acc_addr, acc_data, AW'(k % FRAME), acc_exp_data);
        end
        k++;
      end
    end
    vectors++;
    if (k != 10 || dones != 1) begin
      miscompares++;
      $display("FAIL wrap_counts: writes=%0d done_pulses=%0d, required 10 and 1", k, dones);
    end
    drain();
  endtask

  task automatic test_clr_enable();
    int n, ticks;
    do_reset();
    load(12); enable = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) wait_ev(2, n);
    wait_ev(0, n);
    step();
    addr_clr = 1'b1;
    step();
    addr_clr = 1'b0;
    vectors++;
    if (mem_wr !== 1'b1 || mem_addr !== 4'd5) begin
      miscompares++;
      $display("FAIL clr_write_old: wr=%b addr=%h, required wr=1 addr=5", mem_wr, mem_addr);
    end
    step();
    vectors++;
    if (!acc || acc_addr !== 4'd5 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_accept: accepted=%0d addr=%h done=%b, required accepted=1 addr=5 done=0", acc, acc_addr, frame_done);
    end
    wait_ev(0, n);
    enable = 1'b0;
    wait_ev(2, n);
    vectors++;
    if (n < 0 || acc_addr !== 4'd0 || acc_data !== acc_exp_data) begin
      miscompares++;
      $display("FAIL clr_next_write: steps=%0d addr=%h data=%h, required addr=0 data=%h", n, acc_addr, acc_data, acc_exp_data);
    end
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (data_ready === 1'b1 || frame_done === 1'b1) ticks++;
    end
    vectors++;
    if (ticks != 0) begin miscompares++; $display("FAIL enable_off_ticks: %0d ticks/done pulses, required 0", ticks); end
  endtask

  task automatic test_reset_in_wr();
    int n;
    pix_q.delete(); load(4); enable = 1'b1; mem_ready = 1'b0;
    wait_ev(1, n);
    rstn = 1'b0;
    step();
    vectors++;
    if (mem_wr !== 1'b0 || mem_addr !== '0 || data_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_wr: wr=%b addr=%h ready=%b, required all 0", mem_wr, mem_addr, data_ready);
    end
    rstn = 1'b1; mem_ready = 1'b1;
    wait_ev(2, n);
    vectors++;
    if (n < 0 || acc_addr !== 4'd0 || acc_data !== acc_exp_data) begin
      miscompares++;
      $display("FAIL reset_first_write: steps=%0d addr=%h data=%h, required addr=0 data=%h", n, acc_addr, acc_data, acc_exp_data);
    end
    drain();
  endtask

  task automatic test_random();
    logic prev_wr;
    do_reset();
    pix_q.delete(); load(150);
    prev_wr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      valid_en  = ($urandom_range(0, 7) != 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      addr_clr  = ($urandom_range(0, 29) == 0);
      upd_valid();
      step();
      vectors++;
      if (data_ready !== exp_tick) begin
        miscompares++; $display("FAIL rand_tick cycle %0d: ready=%b, required %b", i, data_ready, exp_tick);
      end
      vectors++;
      if (frame_done !== exp_done) begin
        miscompares++; $display("FAIL rand_done cycle %0d: done=%b, required %b", i, frame_done, exp_done);
      end
      if (acc) begin
        vectors++;
        if (acc_addr !== AW'(acc_exp_addr) || acc_data !== acc_exp_data) begin
          miscompares++;
          $display("FAIL rand_write cycle %0d: addr=%h data=%h, required addr=%h data=%h", i, acc_addr, acc_data, AW'(acc_exp_addr), acc_exp_data);
        end
      end
      if (mem_wr === 1'b1 && prev_wr !== 1'b1) begin
        vectors++;
        if (cyc - tick_cyc != 2) begin
          miscompares++; $display("FAIL rand_latency cycle %0d: %0d cycles tick to write, required 2", i, cyc - tick_cyc);
        end
      end
      prev_wr = mem_wr;
    end
    addr_clr = 1'b0;
    drain();
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; addr_clr = 1'b0; mem_ready = 1'b0;
    valid_en = 1'b0; data_valid = 1'b0; data = '0;
    cyc = 0; tick_cyc = 0;
    test_reset();
    test_single_pixel();
    test_stall();
    test_frame_wrap();
    test_clr_enable();
    test_reset_in_wr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
